// File: rtl/ring_pkg.sv
// ring_pkg: shared FSM state encoding and ring-sequence helper functions.
//   rotl      : rotate-left of the low w bits of a value (w <= 32)
//   is_onehot : true when exactly one bit of a value is set
package ring_pkg;
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    typedef enum logic [1:0] {
        UNLOCKED = ST_UNLOCKED,
        ACQUIRE  = ST_ACQUIRE,
        LOCKED   = ST_LOCKED
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: combinational one-hot to binary index encoder with legality flag.
//   code   : WIDTH-bit candidate one-hot code
//   bin    : index of the set bit (meaningful only when onehot=1)
//   onehot : exactly one bit of code is set
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic [IDX_W-1:0] bin,
    output logic             onehot
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++)
            if (code[i]) bin = bin | IDX_W'(i);
        onehot = is_onehot(32'(code));
    end
endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: one-hot ring sequence decoder with lock FSM and integrity monitor.
//   clk, rst (async active-low), valid, ring_in, clr_err -> inputs
//   idx, idx_valid : index of last legal sample, pulse on update
//   locked         : FSM in LOCKED
//   illegal        : pulse on a valid non-one-hot sample
//   seq_err        : pulse on a sequence break while LOCKED
//   err_count      : saturating count of seq_err, cleared by clr_err
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int IDX_W    = $clog2(WIDTH),
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             illegal,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_count
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

    state_t           state, state_n;
    logic [MW-1:0]    mcnt, mcnt_n, mcnt_inc;
    logic [WIDTH-1:0] prev, expect_v;
    logic [IDX_W-1:0] bin;
    logic             onehot, legal, bad, in_seq, seq_n;

    onehot_to_bin #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .code   (ring_in),
        .bin    (bin),
        .onehot (onehot)
    );

    assign expect_v = WIDTH'(rotl(32'(prev), WIDTH));
    assign legal    = valid & onehot;
    assign bad      = valid & ~onehot;
    assign in_seq   = ring_in == expect_v;
    assign mcnt_inc = mcnt + MW'(1);
    assign locked   = state == LOCKED;

    always_comb begin
        state_n = state;
        mcnt_n  = mcnt;
        seq_n   = 1'b0;
        case (state)
            UNLOCKED: if (legal) begin
                state_n = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                mcnt_n  = MW'(1);
            end
            ACQUIRE: if (bad) begin
                state_n = UNLOCKED;
                mcnt_n  = '0;
            end else if (legal) begin
                // an out-of-sequence sample restarts acquisition from itself
                mcnt_n = in_seq ? mcnt_inc : MW'(1);
                if (in_seq && mcnt_inc >= LOCK_M) state_n = LOCKED;
            end
            LOCKED: if (bad) begin
                seq_n   = 1'b1;
                state_n = UNLOCKED;
                mcnt_n  = '0;
            end else if (legal && !in_seq) begin
                seq_n   = 1'b1;
                state_n = ACQUIRE;
                mcnt_n  = MW'(1);
            end
            default: begin
                state_n = UNLOCKED;
                mcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= UNLOCKED;
            mcnt      <= '0;
            prev      <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            mcnt      <= mcnt_n;
            idx_valid <= legal;
            illegal   <= bad;
            seq_err   <= seq_n;
            if (legal) begin
                prev <= ring_in;
                idx  <= bin;
            end
            err_count <= clr_err ? '0 :
                         (seq_n && !(&err_count)) ? err_count + ERR_W'(1) : err_count;
        end
    end
endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed self-checking bench for ring_decoder (WIDTH=4, LOCK_CNT=2, ERR_W=2).
module tb_ring_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] ring_in = 4'b0;
    logic       clr_err = 1'b0;
    logic [1:0] idx;
    logic       idx_valid, locked, illegal, seq_err;
    logic [1:0] err_count;
    int total = 0;
    int passed = 0;

    ring_decoder #(.WIDTH(4), .LOCK_CNT(2), .ERR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .ring_in   (ring_in),
        .clr_err   (clr_err),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .illegal   (illegal),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drive one sample, let it be clocked in, then settle away from the edge
    task automatic step(input logic v, input logic [3:0] r, input logic c = 1'b0);
        valid   = v;
        ring_in = r;
        clr_err = c;
        @(posedge clk);
        #1;
        valid   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [1:0] e_idx, input logic e_iv,
                        input logic e_lk, input logic e_ill, input logic e_seq,
                        input logic [1:0] e_err);
        chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
        chk({tag, ".idx_valid"}, 32'(idx_valid), 32'(e_iv));
        chk({tag, ".locked"}, 32'(locked), 32'(e_lk));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e_ill));
        chk({tag, ".seq_err"}, 32'(seq_err), 32'(e_seq));
        chk({tag, ".err_count"}, 32'(err_count), 32'(e_err));
    endtask

    initial begin
        #2;
        outs("reset", 2'd0, 0, 0, 0, 0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        // lock and wrap
        step(1, 4'b0001); outs("lk0", 2'd0, 1, 0, 0, 0, 2'd0);
        step(1, 4'b0010); outs("lk1", 2'd1, 1, 1, 0, 0, 2'd0);
        step(1, 4'b0100); outs("lk2", 2'd2, 1, 1, 0, 0, 2'd0);
        step(1, 4'b1000); outs("lk3", 2'd3, 1, 1, 0, 0, 2'd0);
        step(1, 4'b0001); outs("wrap", 2'd0, 1, 1, 0, 0, 2'd0);
        step(0, 4'b0000); outs("idle", 2'd0, 0, 1, 0, 0, 2'd0);
        // sequence break
        step(1, 4'b0010); outs("pre_brk", 2'd1, 1, 1, 0, 0, 2'd0);
        step(1, 4'b1000); outs("brk", 2'd3, 1, 0, 0, 1, 2'd1);
        step(0, 4'b0000); outs("brk_end", 2'd3, 0, 0, 0, 0, 2'd1);
        step(1, 4'b0001); outs("relock0", 2'd0, 1, 1, 0, 0, 2'd1);
        step(1, 4'b0010); outs("relock1", 2'd1, 1, 1, 0, 0, 2'd1);
        // illegal codes while locked
        step(1, 4'b0000); outs("ill_zero", 2'd1, 0, 0, 1, 1, 2'd2);
        step(1, 4'b0100); outs("acq", 2'd2, 1, 0, 0, 0, 2'd2);
        step(1, 4'b1000); outs("acq_lk", 2'd3, 1, 1, 0, 0, 2'd2);
        step(1, 4'b0110); outs("ill_multi", 2'd3, 0, 0, 1, 1, 2'd3);
        step(1, 4'b0110); outs("ill_unlk", 2'd3, 0, 0, 1, 0, 2'd3);
        // valid gaps do not break the sequence
        step(1, 4'b0001); outs("gap0", 2'd0, 1, 0, 0, 0, 2'd3);
        for (int i = 0; i < 5; i++) step(0, 4'b1111);
        outs("gap_hold", 2'd0, 0, 0, 0, 0, 2'd3);
        step(1, 4'b0010); outs("gap1", 2'd1, 1, 1, 0, 0, 2'd3);
        // asynchronous reset mid-stream, checked before the next edge
        rst = 1'b0;
        #2;
        outs("async_rst", 2'd0, 0, 0, 0, 0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(1, 4'b0001); outs("post_rst", 2'd0, 1, 0, 0, 0, 2'd0);
        step(1, 4'b0010); outs("post_lk", 2'd1, 1, 1, 0, 0, 2'd0);
        // saturation: five breaks, each followed by a relock
        for (int i = 1; i <= 5; i++) begin
            step(1, 4'b1000);
            chk("sat.seq_err", 32'(seq_err), 32'd1);
            chk("sat.err_count", 32'(err_count), (i < 3) ? 32'(i) : 32'd3);
            step(1, 4'b0001);
            chk("sat.locked", 32'(locked), 32'd1);
        end
        step(1, 4'b1000, 1'b1); outs("clr_brk", 2'd3, 1, 0, 0, 1, 2'd0);
        step(1, 4'b0001); outs("after_clr", 2'd0, 1, 1, 0, 0, 2'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
